// File: rtl/mem_wb_stage_pkg.sv
// rtl/mem_wb_stage_pkg.sv - shared constants and access-size encodings for the MEM/WB stage
package mem_wb_stage_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int LANES      = DATA_WIDTH / 8;

  // Access size as carried on mem_size; the reserved code behaves as a word.
  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } mem_size_e;

endpackage

// File: rtl/mem_wb_stage_data_memory.sv
// rtl/mem_wb_stage_data_memory.sv - word-organised data memory, async read, byte-lane write
module data_memory
  import mem_wb_stage_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_we,
  input  logic [LANES-1:0]      i_be,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  // No reset: contents survive reset and are undefined at power-up.
  logic [DATA_WIDTH-1:0] r_mem [0:(2**ADDR_WIDTH)-1];

  // Commit only the enabled byte lanes; untouched lanes keep their old value.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int lane = 0; lane < LANES; lane++) begin
        if (i_be[lane]) begin
          r_mem[i_addr][lane*8 +: 8] <= i_wdata[lane*8 +: 8];
        end
      end
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - memory access stage with MEM/WB pipeline register
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  ex_valid,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [1:0]            mem_size,
  input  logic                  mem_signed,
  input  logic                  mem_to_reg_in,
  input  logic                  reg_write_in,
  input  logic [4:0]            write_reg_in,
  input  logic [DATA_WIDTH-1:0] alu_result_in,
  input  logic [DATA_WIDTH-1:0] store_data_in,
  output logic                  wb_valid,
  output logic                  mem_to_reg,
  output logic                  reg_write,
  output logic [4:0]            write_reg,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic [DATA_WIDTH-1:0] alu_result,
  output logic                  misaligned
);

  mem_size_e             w_size;
  logic [1:0]            w_offset;
  logic                  w_aligned;
  logic                  w_access;
  logic                  w_misaligned;
  logic                  w_store_en;
  logic [LANES-1:0]      w_be;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [DATA_WIDTH-1:0] w_load_ext;
  logic [DATA_WIDTH-1:0] w_load_data;

  logic                  r_wb_valid;
  logic                  r_mem_to_reg;
  logic                  r_reg_write;
  logic [4:0]            r_write_reg;
  logic [DATA_WIDTH-1:0] r_read_data;
  logic [DATA_WIDTH-1:0] r_alu_result;
  logic                  r_misaligned;

  assign w_size   = mem_size_e'(mem_size);
  assign w_offset = alu_result_in[1:0];

  // Natural alignment for the requested size; reserved size is checked as a word.
  always_comb begin
    w_aligned = 1'b0;
    case (w_size)
      SIZE_BYTE: w_aligned = 1'b1;
      SIZE_HALF: w_aligned = ~w_offset[0];
      default:   w_aligned = (w_offset == 2'b00);
    endcase
  end

  // A slot only touches memory when it is advancing, not being flushed, and aligned.
  assign w_access     = ex_valid & (mem_read | mem_write) & ~stall & ~flush;
  assign w_misaligned = w_access & ~w_aligned;
  assign w_store_en   = w_access & w_aligned & mem_write & ~reset;

  // Big-endian lane enables and store data replicated across lanes.
  always_comb begin
    w_be    = '0;
    w_wdata = store_data_in;
    case (w_size)
      SIZE_BYTE: begin
        w_be    = 4'b1000 >> w_offset;
        w_wdata = {4{store_data_in[7:0]}};
      end
      SIZE_HALF: begin
        w_be    = w_offset[1] ? 4'b0011 : 4'b1100;
        w_wdata = {2{store_data_in[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = store_data_in;
      end
    endcase
  end

  data_memory #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_data_memory (
    .clk     (clk),
    .i_addr  (alu_result_in[ADDR_WIDTH+1:2]),
    .i_we    (w_store_en),
    .i_be    (w_be),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  // Pick the addressed big-endian lane(s) and extend to a full word.
  always_comb begin
    w_byte     = 8'h00;
    w_half     = w_offset[1] ? w_rdata[15:0] : w_rdata[31:16];
    w_load_ext = w_rdata;
    case (w_offset)
      2'd0:    w_byte = w_rdata[31:24];
      2'd1:    w_byte = w_rdata[23:16];
      2'd2:    w_byte = w_rdata[15:8];
      default: w_byte = w_rdata[7:0];
    endcase
    case (w_size)
      SIZE_BYTE: w_load_ext = {{24{mem_signed & w_byte[7]}}, w_byte};
      SIZE_HALF: w_load_ext = {{16{mem_signed & w_half[15]}}, w_half};
      default:   w_load_ext = w_rdata;
    endcase
  end

  // Only a pure, aligned load returns data; stores, read+write and misaligned slots return zero.
  assign w_load_data = (mem_read & ~mem_write & w_aligned) ? w_load_ext : '0;

  // MEM/WB register: reset and flush clear, stall holds, an invalid slot becomes a bubble.
  always_ff @(posedge clk) begin
    if (reset || flush || (!stall && !ex_valid)) begin
      r_wb_valid   <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_reg_write  <= 1'b0;
      r_write_reg  <= '0;
      r_read_data  <= '0;
      r_alu_result <= '0;
      r_misaligned <= 1'b0;
    end else if (!stall) begin
      r_wb_valid   <= 1'b1;
      r_mem_to_reg <= mem_to_reg_in;
      r_reg_write  <= reg_write_in & ~w_misaligned;
      r_write_reg  <= write_reg_in;
      r_read_data  <= w_load_data;
      r_alu_result <= alu_result_in;
      r_misaligned <= w_misaligned;
    end
  end

  assign wb_valid   = r_wb_valid;
  assign mem_to_reg = r_mem_to_reg;
  assign reg_write  = r_reg_write;
  assign write_reg  = r_write_reg;
  assign read_data  = r_read_data;
  assign alu_result = r_alu_result;
  assign misaligned = r_misaligned;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - directed vector bench for mem_wb_stage
module tb_mem_wb_stage;
  import mem_wb_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset, stall, flush, ex_valid, mem_read, mem_write;
  logic [1:0]  mem_size;
  logic        mem_signed, mem_to_reg_in, reg_write_in;
  logic [4:0]  write_reg_in;
  logic [31:0] alu_result_in, store_data_in;
  logic        wb_valid, mem_to_reg, reg_write, misaligned;
  logic [4:0]  write_reg;
  logic [31:0] read_data, alu_result;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.ADDR_WIDTH(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .flush         (flush),
    .ex_valid      (ex_valid),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_size      (mem_size),
    .mem_signed    (mem_signed),
    .mem_to_reg_in (mem_to_reg_in),
    .reg_write_in  (reg_write_in),
    .write_reg_in  (write_reg_in),
    .alu_result_in (alu_result_in),
    .store_data_in (store_data_in),
    .wb_valid      (wb_valid),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .write_reg     (write_reg),
    .read_data     (read_data),
    .alu_result    (alu_result),
    .misaligned    (misaligned)
  );

  typedef struct {
    string       name;
    logic [5:0]  ctl;    // {reset, stall, flush, ex_valid, mem_read, mem_write}
    logic [1:0]  size;
    logic        sgn, m2r, rw;
    logic [4:0]  wreg;
    logic [31:0] addr, sd;
    logic [3:0]  eflags; // {wb_valid, mem_to_reg, reg_write, misaligned}
    logic [4:0]  ewreg;
    logic [31:0] erd, ealu;
  } vec_t;

  function automatic vec_t mk(string name, logic [5:0] ctl, logic [1:0] size,
                              logic sgn, logic m2r, logic rw, logic [4:0] wreg,
                              logic [31:0] addr, logic [31:0] sd, logic [3:0] eflags,
                              logic [4:0] ewreg, logic [31:0] erd, logic [31:0] ealu);
    vec_t v;
    v.name = name; v.ctl = ctl; v.size = size; v.sgn = sgn; v.m2r = m2r; v.rw = rw;
    v.wreg = wreg; v.addr = addr; v.sd = sd; v.eflags = eflags; v.ewreg = ewreg;
    v.erd = erd; v.ealu = ealu;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    logic [72:0] act, exp;
    @(negedge clk);
    {reset, stall, flush, ex_valid, mem_read, mem_write} = v.ctl;
    mem_size = v.size; mem_signed = v.sgn; mem_to_reg_in = v.m2r; reg_write_in = v.rw;
    write_reg_in = v.wreg; alu_result_in = v.addr; store_data_in = v.sd;
    @(posedge clk);
    #1;
    act = {wb_valid, mem_to_reg, reg_write, misaligned, write_reg, read_data, alu_result};
    exp = {v.eflags, v.ewreg, v.erd, v.ealu};
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got flags=%b wreg=%0d rd=%h alu=%h, want flags=%b wreg=%0d rd=%h alu=%h",
               v.name, act[72:69], act[68:64], act[63:32], act[31:0],
               v.eflags, v.ewreg, v.erd, v.ealu);
    end
  endtask

  vec_t tbl[$];

  initial begin
    {reset, stall, flush, ex_valid, mem_read, mem_write} = 6'b100000;
    mem_size = 2'b00; mem_signed = 0; mem_to_reg_in = 0; reg_write_in = 0;
    write_reg_in = 0; alu_result_in = 0; store_data_in = 0;

    tbl.push_back(mk("reset",      6'b100000, SIZE_WORD, 0,0,0, 0, 32'h0,   32'h0,        4'b0000, 0, 32'h0,        32'h0));
    tbl.push_back(mk("stw_10",     6'b000101, SIZE_WORD, 0,0,0, 0, 32'h10,  32'hDEADBEEF, 4'b1000, 0, 32'h0,        32'h10));
    tbl.push_back(mk("ldw_10",     6'b000110, SIZE_WORD, 0,1,1, 5, 32'h10,  32'h0,        4'b1110, 5, 32'hDEADBEEF, 32'h10));
    tbl.push_back(mk("ldb_11_s",   6'b000110, SIZE_BYTE, 1,1,1, 6, 32'h11,  32'h0,        4'b1110, 6, 32'hFFFFFFAD, 32'h11));
    tbl.push_back(mk("ldb_11_u",   6'b000110, SIZE_BYTE, 0,1,1, 6, 32'h11,  32'h0,        4'b1110, 6, 32'h000000AD, 32'h11));
    tbl.push_back(mk("ldh_12_s",   6'b000110, SIZE_HALF, 1,1,1, 7, 32'h12,  32'h0,        4'b1110, 7, 32'hFFFFBEEF, 32'h12));
    tbl.push_back(mk("ldh_10_u",   6'b000110, SIZE_HALF, 0,1,1, 8, 32'h10,  32'h0,        4'b1110, 8, 32'h0000DEAD, 32'h10));
    tbl.push_back(mk("stb_13",     6'b000101, SIZE_BYTE, 0,0,0, 0, 32'h13,  32'hAAAAAA55, 4'b1000, 0, 32'h0,        32'h13));
    tbl.push_back(mk("ldw_10_b",   6'b000110, SIZE_WORD, 0,1,1, 9, 32'h10,  32'h0,        4'b1110, 9, 32'hDEADBE55, 32'h10));
    tbl.push_back(mk("stw_20",     6'b000101, SIZE_WORD, 0,0,0, 0, 32'h20,  32'h11223344, 4'b1000, 0, 32'h0,        32'h20));
    tbl.push_back(mk("stw_22_mis", 6'b000101, SIZE_WORD, 0,0,1, 3, 32'h22,  32'hFFFFFFFF, 4'b1001, 3, 32'h0,        32'h22));
    tbl.push_back(mk("ldw_20",     6'b000110, SIZE_WORD, 0,1,1, 4, 32'h20,  32'h0,        4'b1110, 4, 32'h11223344, 32'h20));
    tbl.push_back(mk("ldh_21_mis", 6'b000110, SIZE_HALF, 0,1,1, 7, 32'h21,  32'h0,        4'b1101, 7, 32'h0,        32'h21));
    tbl.push_back(mk("bubble",     6'b000010, SIZE_WORD, 0,1,1, 9, 32'h10,  32'h0,        4'b0000, 0, 32'h0,        32'h0));
    tbl.push_back(mk("rdwr_24",    6'b000111, SIZE_WORD, 0,1,1,10, 32'h24,  32'hCAFEF00D, 4'b1110,10, 32'h0,        32'h24));
    tbl.push_back(mk("ldw_24",     6'b000110, SIZE_WORD, 0,1,1,11, 32'h24,  32'h0,        4'b1110,11, 32'hCAFEF00D, 32'h24));
    tbl.push_back(mk("ldw_wrap",   6'b000110, SIZE_WORD, 0,1,1,12, 32'h424, 32'h0,        4'b1110,12, 32'hCAFEF00D, 32'h424));
    tbl.push_back(mk("sth_26",     6'b000101, SIZE_HALF, 0,0,0, 0, 32'h26,  32'hBBBB1234, 4'b1000, 0, 32'h0,        32'h26));
    tbl.push_back(mk("ldw_24_b",   6'b000110, SIZE_WORD, 0,1,1,13, 32'h24,  32'h0,        4'b1110,13, 32'hCAFE1234, 32'h24));
    tbl.push_back(mk("ldb_27_s",   6'b000110, SIZE_BYTE, 1,1,1,14, 32'h27,  32'h0,        4'b1110,14, 32'h00000034, 32'h27));
    tbl.push_back(mk("ldb_25_s",   6'b000110, SIZE_BYTE, 1,1,1,15, 32'h25,  32'h0,        4'b1110,15, 32'hFFFFFFFE, 32'h25));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Stall three cycles with a store pending, then flush while still stalled.
    apply(mk("stl_pre",    6'b000110, SIZE_WORD, 0,1,1, 4, 32'h20, 32'h0,        4'b1110, 4, 32'h11223344, 32'h20));
    for (int i = 0; i < 3; i++)
      apply(mk("stl_hold", 6'b010101, SIZE_WORD, 0,0,0, 0, 32'h20, 32'h99999999, 4'b1110, 4, 32'h11223344, 32'h20));
    apply(mk("stl_flush",  6'b011101, SIZE_WORD, 0,0,0, 0, 32'h20, 32'h99999999, 4'b0000, 0, 32'h0,        32'h0));
    apply(mk("stl_mem",    6'b000110, SIZE_WORD, 0,1,1, 2, 32'h20, 32'h0,        4'b1110, 2, 32'h11223344, 32'h20));

    // Reset during a stall discards the held slot and blocks the pending store.
    apply(mk("rst_pre",    6'b000110, SIZE_WORD, 0,1,1, 1, 32'h10, 32'h0,        4'b1110, 1, 32'hDEADBE55, 32'h10));
    apply(mk("rst_hold",   6'b010110, SIZE_WORD, 0,1,1, 1, 32'h10, 32'h0,        4'b1110, 1, 32'hDEADBE55, 32'h10));
    apply(mk("rst_stall",  6'b110101, SIZE_WORD, 0,1,1, 1, 32'h10, 32'h0,        4'b0000, 0, 32'h0,        32'h0));
    apply(mk("rst_bubble", 6'b000000, SIZE_WORD, 0,0,0, 0, 32'h10, 32'h0,        4'b0000, 0, 32'h0,        32'h0));
    apply(mk("rst_mem",    6'b000110, SIZE_WORD, 0,1,1, 1, 32'h10, 32'h0,        4'b1110, 1, 32'hDEADBE55, 32'h10));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
